vram_scanout: RTL and testbench

Upstream feeder for the HDMI `video` stage. It walks the active display window of the PSX framebuffer (1024x512 halfwords, BGR555) in raster order and fetches one pixel per memory handshake. Each pixel is expanded to RGB888 and buffered in a small show-ahead FIFO, then presented to `video` on its `data`/`en`/`rdy` handshake. It loops frame after frame while enabled.

---
 rtl/psx_video_pkg.sv | 45 ++++
 rtl/vram_scanout_if.sv | 22 ++
 rtl/pixel_fifo.sv | 62 ++++++
 rtl/vram_scanout.sv | 220 ++++++++++++++++++++++
 tb/tb_vram_scanout.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psx_video_pkg.sv
// Shared types and helpers for the PSX framebuffer video path.
package psx_video_pkg;

    localparam int VRAM_W  = 1024;
    localparam int VRAM_H  = 512;
    localparam int VRAM_XW = $clog2(VRAM_W);
    localparam int VRAM_YW = $clog2(VRAM_H);

    // Raw framebuffer pixel; msb is the mask bit and carries no colour.
    typedef struct packed {
        logic       msb;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } bgr555_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FETCH      = 2'd1,
        S_WAIT_SPACE = 2'd2,
        S_DRAIN      = 2'd3
    } scan_state_t;

    // Replicate the top bits into the low bits so full scale maps to 0xFF.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic rgb888_t bgr555_to_rgb888(input bgr555_t px);
        rgb888_t rgb;
        logic    unused_msb;
        unused_msb = px.msb;
        rgb.r = expand5(px.r);
        rgb.g = expand5(px.g);
        rgb.b = expand5(px.b);
        return rgb;
    endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// Memory read port and pixel stream towards the video stage.
interface vram_scanout_if;
    import psx_video_pkg::*;

    logic                         mem_req;
    logic [VRAM_YW+VRAM_XW-1:0]   mem_addr;
    logic                         mem_ack;
    logic [15:0]                  mem_rdata;
    logic [23:0]                  data;
    logic                         en;
    logic                         rdy;

    modport master (
        output mem_req, mem_addr, data, en,
        input  mem_ack, mem_rdata, rdy
    );

    modport slave (
        input  mem_req, mem_addr, data, en,
        output mem_ack, mem_rdata, rdy
    );
endinterface

// File: rtl/pixel_fifo.sv
// Show-ahead pixel buffer: the head entry is visible on rdata whenever not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == {(AW+1){1'b0}});

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/vram_scanout.sv
// Raster-order fetch of the active display window from VRAM into a pixel
// stream for the video stage, one outstanding read at a time.
module vram_scanout
    import psx_video_pkg::*;
#(
    parameter int H_PIXELS   = 720,
    parameter int V_LINES    = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [VRAM_XW-1:0] disp_x,
    input  logic [VRAM_YW-1:0] disp_y,
    vram_scanout_if.master     bus,
    output logic               frame_done,
    output logic               underflow
);
    localparam int XW = VRAM_XW;
    localparam int YW = VRAM_YW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    scan_state_t       state_r, state_next_s;
    logic              req_r, req_next_s;
    logic [YW+XW-1:0]  addr_r, addr_next_s;
    logic [XW-1:0]     x_cnt_r, x_next_s, adv_x_s, org_x_r, org_x_next_s;
    logic [YW-1:0]     y_cnt_r, y_next_s, adv_y_s, org_y_r, org_y_next_s;
    logic              last_pix_s;
    logic              frame_done_r, frame_done_next_s;
    logic              underflow_r, underflow_next_s;
    logic              popped_r;
    logic              push_s, pop_s, flush_s;
    logic              en_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_full_s, fifo_empty_s;
    bgr555_t           head_s;
    rgb888_t           rgb_s;

    pixel_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (bus.mem_rdata),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign en_s          = !fifo_empty_s;
    assign pop_s         = en_s && bus.rdy;
    assign rgb_s         = bgr555_to_rgb888(head_s);
    assign bus.en        = en_s;
    assign bus.data      = en_s ? rgb_s : 24'h00_0000;
    assign bus.mem_req   = req_r;
    assign bus.mem_addr  = addr_r;
    assign frame_done    = frame_done_r;
    assign underflow     = underflow_r;

    // Raster position following the pixel currently being fetched.
    always_comb begin
        adv_x_s    = x_cnt_r + XW'(1);
        adv_y_s    = y_cnt_r;
        last_pix_s = 1'b0;
        if (x_cnt_r == XW'(H_PIXELS - 1)) begin
            adv_x_s = {XW{1'b0}};
            if (y_cnt_r == YW'(V_LINES - 1)) begin
                adv_y_s    = {YW{1'b0}};
                last_pix_s = 1'b1;
            end else begin
                adv_y_s = y_cnt_r + YW'(1);
            end
        end else begin
            adv_x_s = x_cnt_r + XW'(1);
        end
    end

    // Fetch sequencing: request issue, counter advance, frame restart and flush.
    always_comb begin
        state_next_s      = state_r;
        req_next_s        = req_r;
        addr_next_s       = addr_r;
        x_next_s          = x_cnt_r;
        y_next_s          = y_cnt_r;
        org_x_next_s      = org_x_r;
        org_y_next_s      = org_y_r;
        frame_done_next_s = 1'b0;
        push_s            = 1'b0;
        flush_s           = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_next_s = S_FETCH;
                    req_next_s   = 1'b1;
                    org_x_next_s = disp_x;
                    org_y_next_s = disp_y;
                    x_next_s     = {XW{1'b0}};
                    y_next_s     = {YW{1'b0}};
                    addr_next_s  = {disp_y, disp_x};
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (req_r && bus.mem_ack) begin
                    req_next_s = 1'b0;
                    if (enable) begin
                        push_s   = 1'b1;
                        x_next_s = adv_x_s;
                        y_next_s = adv_y_s;
                        if (last_pix_s) begin
                            frame_done_next_s = 1'b1;
                            org_x_next_s      = disp_x;
                            org_y_next_s      = disp_y;
                        end else begin
                            org_x_next_s = org_x_r;
                            org_y_next_s = org_y_r;
                        end
                        addr_next_s = {org_y_next_s + y_next_s, org_x_next_s + x_next_s};
                    end else begin
                        // Ack coincides with disable: the pixel is dropped by the flush.
                        state_next_s = S_IDLE;
                        flush_s      = 1'b1;
                    end
                end else if (req_r) begin
                    if (enable) begin
                        state_next_s = S_FETCH;
                    end else begin
                        state_next_s = S_DRAIN;
                    end
                end else begin
                    if (!enable) begin
                        state_next_s = S_IDLE;
                        flush_s      = 1'b1;
                    end else if (fifo_full_s) begin
                        state_next_s = S_WAIT_SPACE;
                    end else begin
                        req_next_s = 1'b1;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (!enable) begin
                    state_next_s = S_IDLE;
                    flush_s      = 1'b1;
                end else if (fifo_count_s < CW'(FIFO_DEPTH)) begin
                    state_next_s = S_FETCH;
                    req_next_s   = 1'b1;
                end else begin
                    state_next_s = S_WAIT_SPACE;
                end
            end
            S_DRAIN: begin
                if (bus.mem_ack) begin
                    state_next_s = S_IDLE;
                    req_next_s   = 1'b0;
                    flush_s      = 1'b1;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                req_next_s   = 1'b0;
                flush_s      = 1'b1;
            end
        endcase
    end

    // Starvation detect: only counts once the stream has actually started.
    always_comb begin
        underflow_next_s = underflow_r;
        if (bus.rdy && !en_s && (state_r != S_IDLE) && popped_r) begin
            underflow_next_s = 1'b1;
        end else begin
            underflow_next_s = underflow_r;
        end
    end

    // State, request and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            req_r        <= 1'b0;
            addr_r       <= {(YW+XW){1'b0}};
            x_cnt_r      <= {XW{1'b0}};
            y_cnt_r      <= {YW{1'b0}};
            org_x_r      <= {XW{1'b0}};
            org_y_r      <= {YW{1'b0}};
            frame_done_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            req_r        <= req_next_s;
            addr_r       <= addr_next_s;
            x_cnt_r      <= x_next_s;
            y_cnt_r      <= y_next_s;
            org_x_r      <= org_x_next_s;
            org_y_r      <= org_y_next_s;
            frame_done_r <= frame_done_next_s;
            underflow_r  <= underflow_next_s;
        end
    end

    // Remember that a pixel has been consumed since the stream (re)started.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            popped_r <= 1'b0;
        end else if (pop_s) begin
            popped_r <= 1'b1;
        end else begin
            popped_r <= popped_r;
        end
    end
endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout: directed sequences, a colour table
// and a randomized run against a queue-based reference model.
module tb_vram_scanout;
    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] disp_x;
    logic [8:0] disp_y;
    logic       frame_done;
    logic       underflow;

    vram_scanout_if bus();

    vram_scanout #(
        .H_PIXELS   (H),
        .V_LINES    (V),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .disp_x     (disp_x),
        .disp_y     (disp_y),
        .bus        (bus),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] rd;
        logic [23:0] rgb;
    } color_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_rgb(input logic [15:0] rd);
        int r5, g5, b5, r8, g8, b8;
        r5 = int'(rd) % 32;
        g5 = (int'(rd) / 32) % 32;
        b5 = (int'(rd) / 1024) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g5 * 8 + g5 / 4;
        b8 = b5 * 8 + b5 / 4;
        return 24'(r8 * 65536 + g8 * 256 + b8);
    endfunction

    function automatic logic [31:0] exp_addr(input int ox, input int oy, input int k);
        int x, y;
        x = (ox + k % H) % 1024;
        y = (oy + k / H) % 512;
        return 32'(y * 1024 + x);
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        enable        = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.rdy       = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int t;
        t = 0;
        while (bus.mem_req !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        check({name, "_req"}, 32'(bus.mem_req), 32'd1);
    endtask

    // One memory transaction with checks on address, response and frame pulse.
    task automatic fetch(input string name, input logic [31:0] addr, input logic [15:0] rd,
                         input logic [23:0] head, input logic fd);
        wait_req(name);
        check({name, "_addr"}, 32'(bus.mem_addr), addr);
        check({name, "_fd_pre"}, 32'(frame_done), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        step();
        bus.mem_ack = 1'b0;
        check({name, "_req_low"}, 32'(bus.mem_req), 32'd0);
        check({name, "_en"}, 32'(bus.en), 32'd1);
        check({name, "_data"}, 32'(bus.data), 32'(head));
        check({name, "_fd"}, 32'(frame_done), 32'(fd));
    endtask

    initial begin
        color_vec_t  ctab[8];
        logic [23:0] q[$];
        logic [15:0] rd_i;
        logic        ack_i, req_m, popped_m, uf_m, fd_m;
        int          ox, oy, pix, size_c;

        disp_x = 10'd0;
        disp_y = 9'd0;

        // Reset values
        rst           = 1'b1;
        enable        = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.rdy       = 1'b0;
        step();
        step();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_en", 32'(bus.en), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);
        rst = 1'b0;

        // Basic fill, then the wrap case
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            disp_x  = (pass == 0) ? 10'd0 : 10'd1022;
            disp_y  = (pass == 0) ? 9'd0 : 9'd511;
            bus.rdy = 1'b1;
            enable  = 1'b1;
            step();
            for (int k = 0; k < 9; k++) begin
                logic [15:0] rd;
                rd = 16'(16'h1234 + k * 16'h0421);
                fetch((pass == 0) ? "basic" : "wrap", exp_addr(int'(disp_x), int'(disp_y), k % (H * V)),
                      rd, exp_rgb(rd), k == H * V - 1);
            end
        end

        // Colour conversion table
        ctab[0] = '{16'h7FFF, 24'hFFFFFF};
        ctab[1] = '{16'h001F, 24'hFF0000};
        ctab[2] = '{16'h03E0, 24'h00FF00};
        ctab[3] = '{16'h7C00, 24'h0000FF};
        ctab[4] = '{16'h8000, 24'h000000};
        ctab[5] = '{16'h0001, 24'h080000};
        ctab[6] = '{16'h0421, 24'h080808};
        ctab[7] = '{16'h5294, 24'hA5A5A5};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            disp_x = 10'd0;
            disp_y = 9'd0;
            enable = 1'b1;
            step();
            fetch("color", 32'd0, ctab[i].rd, ctab[i].rgb, 1'b0);
        end

        // Back-pressure with a full FIFO, then a single pop
        do_reset();
        disp_x = 10'd5;
        disp_y = 9'd3;
        enable = 1'b1;
        step();
        for (int k = 0; k < D; k++) begin
            fetch("bp_fill", exp_addr(5, 3, k), 16'(16'h0100 + k), exp_rgb(16'h0100), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_req_held", 32'(bus.mem_req), 32'd0);
            check("bp_data_stable", 32'(bus.data), 32'(exp_rgb(16'h0100)));
        end
        bus.rdy = 1'b1;
        step();
        bus.rdy = 1'b0;
        check("bp_pop_data", 32'(bus.data), 32'(exp_rgb(16'h0101)));
        check("bp_req_p", 32'(bus.mem_req), 32'd0);
        step();
        check("bp_req_p1", 32'(bus.mem_req), 32'd1);
        check("bp_addr_p1", 32'(bus.mem_addr), exp_addr(5, 3, D));

        // Underflow after the first pop, sticky until reset
        do_reset();
        disp_x  = 10'd0;
        disp_y  = 9'd0;
        bus.rdy = 1'b1;
        enable  = 1'b1;
        step();
        wait_req("uf");
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7FFF;
        step();
        bus.mem_ack = 1'b0;
        check("uf_before_pop", 32'(underflow), 32'd0);
        step();
        check("uf_at_pop", 32'(underflow), 32'd0);
        check("uf_en_empty", 32'(bus.en), 32'd0);
        step();
        check("uf_set", 32'(underflow), 32'd1);
        enable = 1'b0;
        step();
        step();
        step();
        check("uf_sticky", 32'(underflow), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("uf_cleared", 32'(underflow), 32'd0);

        // Disable while a request is outstanding
        do_reset();
        disp_x = 10'd0;
        disp_y = 9'd0;
        enable = 1'b1;
        step();
        check("dis_req", 32'(bus.mem_req), 32'd1);
        enable = 1'b0;
        step();
        check("dis_drain_req", 32'(bus.mem_req), 32'd1);
        step();
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7FFF;
        step();
        bus.mem_ack = 1'b0;
        check("dis_req_low", 32'(bus.mem_req), 32'd0);
        check("dis_no_push", 32'(bus.en), 32'd0);
        step();
        check("dis_idle_en", 32'(bus.en), 32'd0);
        check("dis_idle_req", 32'(bus.mem_req), 32'd0);
        disp_x = 10'd7;
        disp_y = 9'd2;
        enable = 1'b1;
        step();
        check("dis_restart_req", 32'(bus.mem_req), 32'd1);
        check("dis_restart_addr", 32'(bus.mem_addr), exp_addr(7, 2, 0));

        // Reset in the middle of a frame
        do_reset();
        disp_x = 10'd9;
        disp_y = 9'd1;
        enable = 1'b1;
        step();
        fetch("mid", exp_addr(9, 1, 0), 16'h1111, exp_rgb(16'h1111), 1'b0);
        wait_req("mid2");
        rst = 1'b1;
        step();
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_en", 32'(bus.en), 32'd0);
        check("mid_rst_data", 32'(bus.data), 32'd0);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        check("mid_rst_uf", 32'(underflow), 32'd0);
        rst = 1'b0;

        // Randomized run against the reference model
        do_reset();
        disp_x = 10'($urandom);
        disp_y = 9'($urandom);
        enable = 1'b1;
        ox = int'(disp_x);
        oy = int'(disp_y);
        step();
        pix      = 0;
        req_m    = 1'b1;
        popped_m = 1'b0;
        uf_m     = 1'b0;
        q.delete();
        check("rnd_start_req", 32'(bus.mem_req), 32'd1);
        check("rnd_start_addr", 32'(bus.mem_addr), exp_addr(ox, oy, 0));
        for (int c = 0; c < 1500; c++) begin
            ack_i         = req_m && ($urandom_range(0, 1) == 1);
            rd_i          = 16'($urandom);
            bus.mem_ack   = ack_i;
            bus.mem_rdata = rd_i;
            bus.rdy       = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                disp_x = 10'($urandom);
                disp_y = 9'($urandom);
            end
            size_c = q.size();
            if (bus.rdy && size_c == 0 && popped_m) begin
                uf_m = 1'b1;
            end
            if (bus.rdy && size_c > 0) begin
                void'(q.pop_front());
                popped_m = 1'b1;
            end
            fd_m = 1'b0;
            if (ack_i) begin
                q.push_back(exp_rgb(rd_i));
                pix++;
                if (pix == H * V) begin
                    pix  = 0;
                    fd_m = 1'b1;
                    ox   = int'(disp_x);
                    oy   = int'(disp_y);
                end
            end
            req_m = ack_i ? 1'b0 : (req_m || size_c < D);
            step();
            check("rnd_req", 32'(bus.mem_req), 32'(req_m));
            if (req_m) begin
                check("rnd_addr", 32'(bus.mem_addr), exp_addr(ox, oy, pix));
            end
            check("rnd_en", 32'(bus.en), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("rnd_data", 32'(bus.data), 32'(q[0]));
            end
            check("rnd_fd", 32'(frame_done), 32'(fd_m));
            check("rnd_uf", 32'(underflow), 32'(uf_m));
        end
        bus.mem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
